// File: rtl/hwtimer_bank_if.sv
// -----------------------------------------------------------------------------
// hwtimer_bank_if
// Request/response register bus used by the hwregs address decoder, reused
// for the timer bank window.
//   tmr_request  single-cycle read or write request
//   tmr_write    1 = write, 0 = read
//   tmr_address  byte address inside the 256-byte window, bits [1:0] ignored
//   tmr_wmask    write byte-lane enables
//   tmr_wdata    write data; on reads bits [8:0] carry the tag
//   tmr_rvalid   read response valid, one cycle after the request
//   tmr_rtag     tag echoed from the read request
//   tmr_rdata    read data, 0 whenever tmr_rvalid is low
// -----------------------------------------------------------------------------
interface hwtimer_bank_if;
  logic        tmr_request;
  logic        tmr_write;
  logic [7:0]  tmr_address;
  logic [3:0]  tmr_wmask;
  logic [31:0] tmr_wdata;
  logic        tmr_rvalid;
  logic [8:0]  tmr_rtag;
  logic [31:0] tmr_rdata;

  modport master (
    output tmr_request, tmr_write, tmr_address, tmr_wmask, tmr_wdata,
    input  tmr_rvalid, tmr_rtag, tmr_rdata
  );

  modport slave (
    input  tmr_request, tmr_write, tmr_address, tmr_wmask, tmr_wdata,
    output tmr_rvalid, tmr_rtag, tmr_rdata
  );
endinterface

// File: rtl/hwtimer_bank.sv
// -----------------------------------------------------------------------------
// hwtimer_bank
// NUM_TIMERS independent prescaled down-counters with reload, one-shot or
// auto-reload mode and a sticky pending flag, behind the register bus.
//   clock      system clock
//   reset      synchronous, active-high
//   bus        register bus slave (see hwtimer_bank_if)
//   timer_irq  per-channel pending & irq_enable
//   irq        OR of timer_irq
// Map: channel n at 0x10*n: +0 COUNT, +4 RELOAD, +8 CTRL, +C STATUS (W1C).
//      0x80 IRQ_STATUS: pending bitmask, write 1 to clear.
// CTRL: bit0 enable, bit1 auto_reload, bit2 irq_enable, [31:16] prescale.
// -----------------------------------------------------------------------------
module hwtimer_bank #(
  parameter int NUM_TIMERS = 4,
  parameter int WIDTH      = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  hwtimer_bank_if.slave         bus,
  output logic [NUM_TIMERS-1:0] timer_irq,
  output logic                  irq
);

  typedef enum logic [1:0] {
    REG_COUNT  = 2'd0,
    REG_RELOAD = 2'd1,
    REG_CTRL   = 2'd2,
    REG_STATUS = 2'd3
  } reg_sel_e;

  // Channel state
  logic [WIDTH-1:0]      r_count    [NUM_TIMERS];
  logic [WIDTH-1:0]      r_reload   [NUM_TIMERS];
  logic [15:0]           r_prescale [NUM_TIMERS];
  logic [15:0]           r_pcnt     [NUM_TIMERS];
  logic [NUM_TIMERS-1:0] r_enable;
  logic [NUM_TIMERS-1:0] r_auto;
  logic [NUM_TIMERS-1:0] r_irq_en;
  logic [NUM_TIMERS-1:0] r_pending;

  // Read response
  logic        r_rvalid;
  logic [8:0]  r_rtag;
  logic [31:0] r_rdata;

  // Address decode
  logic        w_rd;
  logic        w_wr;
  logic        w_in_chan;
  logic        w_is_irq_status;
  logic [2:0]  w_chan;
  reg_sel_e    w_reg;
  logic [31:0] w_lane_mask;
  logic [31:0] w_read_data;
  logic [1:0]  w_unused_addr_lsbs;

  assign w_rd               = bus.tmr_request & ~bus.tmr_write;
  assign w_wr               = bus.tmr_request &  bus.tmr_write;
  assign w_in_chan          = ~bus.tmr_address[7];
  assign w_is_irq_status    = (bus.tmr_address[7:2] == 6'b10_0000);
  assign w_chan             = bus.tmr_address[6:4];
  assign w_reg              = reg_sel_e'(bus.tmr_address[3:2]);
  assign w_unused_addr_lsbs = bus.tmr_address[1:0];
  assign w_lane_mask        = {{8{bus.tmr_wmask[3]}}, {8{bus.tmr_wmask[2]}},
                               {8{bus.tmr_wmask[1]}}, {8{bus.tmr_wmask[0]}}};

  // Per-channel events and byte-lane merged write values
  logic [NUM_TIMERS-1:0] w_sel;
  logic [NUM_TIMERS-1:0] w_tick;
  logic [NUM_TIMERS-1:0] w_expire;
  logic [NUM_TIMERS-1:0] w_clear;
  logic [WIDTH-1:0]      w_count_wval    [NUM_TIMERS];
  logic [WIDTH-1:0]      w_reload_wval   [NUM_TIMERS];
  logic [15:0]           w_prescale_wval [NUM_TIMERS];

  for (genvar n = 0; n < NUM_TIMERS; n++) begin : g_chan
    assign w_sel[n]    = w_wr & w_in_chan & (w_chan == 3'(n));
    assign w_tick[n]   = r_enable[n] & (r_pcnt[n] == r_prescale[n]);
    assign w_expire[n] = w_tick[n] & (r_count[n] == '0);

    // Both clear paths live in byte lane 0.
    assign w_clear[n]  = w_wr & bus.tmr_wmask[0] &
                         ((w_sel[n] & (w_reg == REG_STATUS) & bus.tmr_wdata[0]) |
                          (w_is_irq_status & bus.tmr_wdata[n]));

    // Bits above WIDTH-1 simply do not exist, so they are dropped on write.
    assign w_count_wval[n]    = (r_count[n] & ~w_lane_mask[WIDTH-1:0]) |
                                (bus.tmr_wdata[WIDTH-1:0] & w_lane_mask[WIDTH-1:0]);
    assign w_reload_wval[n]   = (r_reload[n] & ~w_lane_mask[WIDTH-1:0]) |
                                (bus.tmr_wdata[WIDTH-1:0] & w_lane_mask[WIDTH-1:0]);
    assign w_prescale_wval[n] = (r_prescale[n] & ~w_lane_mask[31:16]) |
                                (bus.tmr_wdata[31:16] & w_lane_mask[31:16]);
  end

  // Channel state update
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the channel arrays are plain flops read by software right after
      // reset, so every element is cleared explicitly rather than left to a RAM.
      for (int n = 0; n < NUM_TIMERS; n++) begin
        r_count[n]    <= '0;
        r_reload[n]   <= '0;
        r_prescale[n] <= '0;
        r_pcnt[n]     <= '0;
      end
      r_enable  <= '0;
      r_auto    <= '0;
      r_irq_en  <= '0;
      r_pending <= '0;
    end else begin
      // NOTE: non-blocking assignments only; where two statements below touch
      // the same register, the later one (the bus write) deliberately wins.
      for (int n = 0; n < NUM_TIMERS; n++) begin
        // A COUNT write overrides any decrement or reload in the same cycle.
        if (w_sel[n] && (w_reg == REG_COUNT)) begin
          r_count[n] <= w_count_wval[n];
        end else if (w_expire[n]) begin
          if (r_auto[n]) r_count[n] <= r_reload[n];
        end else if (w_tick[n]) begin
          r_count[n] <= r_count[n] - WIDTH'(1);
        end

        if (w_sel[n] && (w_reg == REG_RELOAD)) r_reload[n] <= w_reload_wval[n];

        // One-shot expiry stops the channel unless CTRL is rewritten now.
        if (w_expire[n] && !r_auto[n]) r_enable[n] <= 1'b0;
        if (w_sel[n] && (w_reg == REG_CTRL)) begin
          if (bus.tmr_wmask[0]) begin
            r_enable[n] <= bus.tmr_wdata[0];
            r_auto[n]   <= bus.tmr_wdata[1];
            r_irq_en[n] <= bus.tmr_wdata[2];
          end
          r_prescale[n] <= w_prescale_wval[n];
        end

        // Disabled channels hold pcnt at 0, so a fresh enable starts a full
        // prescale+1 period.
        if (!r_enable[n] || w_tick[n]) r_pcnt[n] <= '0;
        else                           r_pcnt[n] <= r_pcnt[n] + 16'd1;

        // Set beats clear when both happen in one cycle.
        if (w_expire[n])     r_pending[n] <= 1'b1;
        else if (w_clear[n]) r_pending[n] <= 1'b0;
      end
    end
  end

  // Read mux, evaluated on pre-update state
  always_comb begin
    // NOTE: default first so every path assigns it and no latch is inferred.
    w_read_data = '0;
    if (w_is_irq_status) begin
      w_read_data[NUM_TIMERS-1:0] = r_pending;
    end else if (w_in_chan) begin
      for (int n = 0; n < NUM_TIMERS; n++) begin
        if (w_chan == 3'(n)) begin
          case (w_reg)
            REG_COUNT:  w_read_data[WIDTH-1:0] = r_count[n];
            REG_RELOAD: w_read_data[WIDTH-1:0] = r_reload[n];
            REG_CTRL:   w_read_data = {r_prescale[n], 13'd0, r_irq_en[n], r_auto[n], r_enable[n]};
            REG_STATUS: w_read_data[0] = r_pending[n];
            default:    w_read_data = '0;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rvalid <= 1'b0;
      r_rtag   <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= w_rd;
      r_rdata  <= w_rd ? w_read_data : 32'd0;
      if (w_rd) r_rtag <= bus.tmr_wdata[8:0];
    end
  end

  assign bus.tmr_rvalid = r_rvalid;
  assign bus.tmr_rtag   = r_rtag;
  assign bus.tmr_rdata  = r_rdata;

  assign timer_irq = r_pending & r_irq_en;
  assign irq       = |timer_irq;

endmodule

// File: tb/tb_hwtimer_bank.sv
// -----------------------------------------------------------------------------
// tb_hwtimer_bank
// Two banks share one stimulus stream: A with default parameters (4 x 32 bit)
// and B with NUM_TIMERS=2, WIDTH=16. A behavioural model of both banks runs
// alongside; a compare process checks every cycle, and directed sections pin
// hand-computed values.
// -----------------------------------------------------------------------------
module tb_hwtimer_bank;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  hwtimer_bank_if bus_a ();
  hwtimer_bank_if bus_b ();

  assign bus_b.tmr_request = bus_a.tmr_request;
  assign bus_b.tmr_write   = bus_a.tmr_write;
  assign bus_b.tmr_address = bus_a.tmr_address;
  assign bus_b.tmr_wmask   = bus_a.tmr_wmask;
  assign bus_b.tmr_wdata   = bus_a.tmr_wdata;

  logic [3:0] tirq_a;
  logic       irq_a;
  logic [1:0] tirq_b;
  logic       irq_b;

  hwtimer_bank #(.NUM_TIMERS(4), .WIDTH(32)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.slave), .timer_irq(tirq_a), .irq(irq_a)
  );

  hwtimer_bank #(.NUM_TIMERS(2), .WIDTH(16)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.slave), .timer_irq(tirq_b), .irq(irq_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: index 0 = bank A, 1 = bank B
  // ---------------------------------------------------------------------------
  logic [31:0] m_count  [2][8];
  logic [31:0] m_reload [2][8];
  logic [15:0] m_ps     [2][8];
  logic [15:0] m_pcnt   [2][8];
  bit          m_en     [2][8];
  bit          m_ar     [2][8];
  bit          m_ie     [2][8];
  bit          m_pend   [2][8];
  bit          e_rvalid [2];
  logic [8:0]  e_rtag   [2];
  logic [31:0] e_rdata  [2];
  bit          model_live = 1'b0;

  function automatic int nt_of(input int d);
    return (d == 0) ? 4 : 2;
  endfunction

  function automatic logic [31:0] value_mask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
  endfunction

  function automatic logic [7:0] m_irqvec(input int d);
    logic [7:0] v;
    v = '0;
    for (int n = 0; n < nt_of(d); n++) v[n] = m_pend[d][n] & m_ie[d][n];
    return v;
  endfunction

  function automatic logic [31:0] model_read(input int d, input logic [7:0] ai);
    logic [31:0] r;
    int ch, off;
    r   = '0;
    ch  = int'(ai) / 16;
    off = int'(ai) % 16;
    if (ai == 8'h80) begin
      for (int n = 0; n < nt_of(d); n++) r[n] = m_pend[d][n];
    end else if (ai < 8'h80 && ch < nt_of(d)) begin
      case (off)
        0:  r = m_count[d][ch];
        4:  r = m_reload[d][ch];
        8:  r = {m_ps[d][ch], 13'h0, m_ie[d][ch], m_ar[d][ch], m_en[d][ch]};
        12: r = {31'h0, m_pend[d][ch]};
        default: r = '0;
      endcase
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 8; n++) begin
        m_count[d][n] = '0; m_reload[d][n] = '0; m_ps[d][n] = '0; m_pcnt[d][n] = '0;
        m_en[d][n] = 0; m_ar[d][n] = 0; m_ie[d][n] = 0; m_pend[d][n] = 0;
      end
      e_rvalid[d] = 0; e_rtag[d] = '0; e_rdata[d] = '0;
    end
  endtask

  task automatic model_step(input int d);
    logic [31:0] lm, wd, cnt_n, rel_n;
    logic [15:0] ps_n, pc_n;
    logic [7:0]  ai;
    int          ch, off;
    bit          rq, wr, tick, expire, hit, clr, en_n, ar_n, ie_n, pd_n;
    rq  = bus_a.tmr_request;
    wr  = bus_a.tmr_write;
    wd  = bus_a.tmr_wdata;
    ai  = bus_a.tmr_address & 8'hFC;
    ch  = int'(ai) / 16;
    off = int'(ai) % 16;
    for (int b = 0; b < 4; b++) lm[8*b +: 8] = {8{bus_a.tmr_wmask[b]}};

    e_rvalid[d] = rq && !wr;
    e_rdata[d]  = (rq && !wr) ? model_read(d, ai) : 32'h0;
    if (rq && !wr) e_rtag[d] = wd[8:0];

    for (int n = 0; n < nt_of(d); n++) begin
      tick   = m_en[d][n] && (m_pcnt[d][n] == m_ps[d][n]);
      expire = tick && (m_count[d][n] == 0);
      hit    = rq && wr && (ai < 8'h80) && (ch == n);
      pc_n   = (!m_en[d][n] || tick) ? 16'h0 : m_pcnt[d][n] + 16'h1;
      cnt_n  = m_count[d][n];
      if (expire)    cnt_n = m_ar[d][n] ? m_reload[d][n] : 32'h0;
      else if (tick) cnt_n = m_count[d][n] - 1;
      en_n   = (expire && !m_ar[d][n]) ? 1'b0 : m_en[d][n];
      ar_n   = m_ar[d][n];
      ie_n   = m_ie[d][n];
      ps_n   = m_ps[d][n];
      rel_n  = m_reload[d][n];
      clr    = rq && wr && bus_a.tmr_wmask[0] &&
               ((hit && off == 12 && wd[0]) || (ai == 8'h80 && wd[n]));
      pd_n   = expire ? 1'b1 : (clr ? 1'b0 : m_pend[d][n]);
      if (hit) begin
        case (off)
          0: cnt_n = ((m_count[d][n] & ~lm) | (wd & lm)) & value_mask(d);
          4: rel_n = ((m_reload[d][n] & ~lm) | (wd & lm)) & value_mask(d);
          8: begin
            if (bus_a.tmr_wmask[0]) begin
              en_n = wd[0]; ar_n = wd[1]; ie_n = wd[2];
            end
            ps_n = (m_ps[d][n] & ~lm[31:16]) | (wd[31:16] & lm[31:16]);
          end
          default: ;
        endcase
      end
      m_count[d][n] = cnt_n; m_reload[d][n] = rel_n; m_ps[d][n] = ps_n; m_pcnt[d][n] = pc_n;
      m_en[d][n] = en_n; m_ar[d][n] = ar_n; m_ie[d][n] = ie_n; m_pend[d][n] = pd_n;
    end
  endtask

  function automatic bit m_ch0_expiring();
    return m_en[0][0] && (m_pcnt[0][0] == m_ps[0][0]) && (m_count[0][0] == 0);
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      if (reset) model_reset();
      else for (int d = 0; d < 2; d++) model_step(d);
      model_live = 1'b1;
    end
  end

  // Per-cycle compare, away from the active edge
  initial begin
    forever begin
      @(negedge clock);
      if (model_live) begin
        check("a_rvalid", 32'(bus_a.tmr_rvalid), 32'(e_rvalid[0]));
        check("a_rdata",  bus_a.tmr_rdata, e_rdata[0]);
        if (e_rvalid[0]) check("a_rtag", 32'(bus_a.tmr_rtag), 32'(e_rtag[0]));
        check("a_timer_irq", 32'(tirq_a), 32'(m_irqvec(0)));
        check("a_irq", 32'(irq_a), 32'(|m_irqvec(0)));
        check("b_rvalid", 32'(bus_b.tmr_rvalid), 32'(e_rvalid[1]));
        check("b_rdata",  bus_b.tmr_rdata, e_rdata[1]);
        if (e_rvalid[1]) check("b_rtag", 32'(bus_b.tmr_rtag), 32'(e_rtag[1]));
        check("b_timer_irq", 32'(tirq_b), 32'(m_irqvec(1)));
        check("b_irq", 32'(irq_b), 32'(|m_irqvec(1)));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change 1 time unit after the rising edge
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus_a.tmr_request = 1'b0;
    bus_a.tmr_write   = 1'b0;
    bus_a.tmr_address = '0;
    bus_a.tmr_wmask   = '0;
    bus_a.tmr_wdata   = '0;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] m = 4'hF);
    bus_a.tmr_request = 1'b1;
    bus_a.tmr_write   = 1'b1;
    bus_a.tmr_address = a;
    bus_a.tmr_wmask   = m;
    bus_a.tmr_wdata   = d;
    tick();
    idle();
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [8:0] tag,
                          output logic [31:0] da, output logic [31:0] db);
    bus_a.tmr_request = 1'b1;
    bus_a.tmr_write   = 1'b0;
    bus_a.tmr_address = a;
    bus_a.tmr_wmask   = 4'($urandom);
    bus_a.tmr_wdata   = {23'($urandom), tag};
    tick();
    da = bus_a.tmr_rdata;
    db = bus_b.tmr_rdata;
    idle();
  endtask

  task automatic rand_req();
    logic [7:0]  a;
    logic [31:0] d;
    int          sel, rsel;
    sel  = $urandom_range(0, 19);
    rsel = sel % 4;
    if (sel < 16)      a = {1'b0, 3'($urandom_range(0, 4)), 2'(rsel), 2'($urandom_range(0, 3))};
    else if (sel < 18) a = {6'b10_0000, 2'($urandom_range(0, 3))};
    else               a = 8'($urandom);
    d = $urandom;
    if (sel < 16 && rsel < 2 && $urandom_range(0, 7) != 0) d = $urandom_range(0, 12);
    if (sel < 16 && rsel == 2) d[31:16] = 16'($urandom_range(0, 3));
    bus_a.tmr_request = ($urandom_range(0, 3) != 0);
    bus_a.tmr_write   = 1'($urandom_range(0, 1));
    bus_a.tmr_address = a;
    bus_a.tmr_wmask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
    bus_a.tmr_wdata   = d;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] da, db;
    bit          found;

    idle();
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    check("reset_irq_a", 32'(irq_a), 32'h0);
    check("reset_rvalid_a", 32'(bus_a.tmr_rvalid), 32'h0);

    // Reset sweep: every address reads 0 with the tag echoed
    for (int a = 0; a <= 'h84; a += 4) begin
      bus_read(8'(a), 9'h1A5, da, db);
      check("sweep_rvalid_a", 32'(bus_a.tmr_rvalid), 32'h1);
      check("sweep_rtag_a", 32'(bus_a.tmr_rtag), 32'h1A5);
      check("sweep_rtag_b", 32'(bus_b.tmr_rtag), 32'h1A5);
      check("sweep_rdata_a", da, 32'h0);
      check("sweep_rdata_b", db, 32'h0);
      check("sweep_irq_a", 32'(irq_a), 32'h0);
    end
    tick();
    check("rvalid_single_cycle_a", 32'(bus_a.tmr_rvalid), 32'h0);

    // Ch0 auto-reload, prescale 0, period 5
    bus_write(8'h04, 32'd4);
    bus_write(8'h00, 32'd4);
    bus_write(8'h08, 32'h7);
    check("ch0_irq_before", 32'(irq_a), 32'h0);
    for (int i = 0; i < 10; i++) begin
      bus_read(8'h00, 9'(i), da, db);
      check("ch0_count_a", da, 32'(4 - (i % 5)));
      check("ch0_count_b", db, 32'(4 - (i % 5)));
    end
    check("ch0_irq_after", 32'(irq_a), 32'h1);

    // Ch1 one-shot, prescale 3: expiry 12 cycles after the enable write
    bus_write(8'h10, 32'd2);
    bus_write(8'h18, 32'h0003_0005);
    for (int i = 0; i < 13; i++) begin
      bus_read(8'h1C, 9'h0, da, db);
      check("ch1_pending_a", da, (i >= 12) ? 32'h1 : 32'h0);
    end
    bus_read(8'h18, 9'h0, da, db);
    check("ch1_ctrl_a", da, 32'h0003_0004);
    check("ch1_ctrl_b", db, 32'h0003_0004);
    bus_read(8'h10, 9'h0, da, db);
    check("ch1_count_a", da, 32'h0);
    check("ch1_timer_irq_a", 32'(tirq_a[1]), 32'h1);

    // W1C collides with ch0 expiry: set wins; next-cycle W1C clears
    bus_write(8'h1C, 32'h1);
    found = 1'b0;
    for (int k = 0; k < 12 && !found; k++) begin
      if (m_ch0_expiring()) found = 1'b1;
      else tick();
    end
    check("w1c_expiry_found", 32'(found), 32'h1);
    bus_write(8'h80, 32'h1);
    check("w1c_collide_irq_a", 32'(irq_a), 32'h1);
    check("w1c_collide_irq_b", 32'(irq_b), 32'h1);
    bus_write(8'h80, 32'h1);
    check("w1c_clear_irq_a", 32'(irq_a), 32'h0);
    check("w1c_clear_irq_b", 32'(irq_b), 32'h0);
    bus_read(8'h0C, 9'h0, da, db);
    check("w1c_status_a", da, 32'h0);

    // Byte lanes
    bus_write(8'h14, 32'hAABB_CCDD, 4'b0010);
    bus_read(8'h14, 9'h0, da, db);
    check("lane_reload_a", da, 32'h0000_CC00);
    check("lane_reload_b", db, 32'h0000_CC00);

    // Width and channel-count boundaries
    bus_write(8'h10, 32'hFFFF_FFFF);
    bus_read(8'h10, 9'h0, da, db);
    check("wide_count_a", da, 32'hFFFF_FFFF);
    check("narrow_count_b", db, 32'h0000_FFFF);
    bus_read(8'h20, 9'h0, da, db);
    check("unmapped_ch2_b", db, 32'h0);

    // COUNT write in a tick cycle (ch0 ticks every cycle): no decrement
    bus_write(8'h00, 32'd100);
    bus_read(8'h00, 9'h0, da, db);
    check("count_wr_tick_a", da, 32'd100);
    check("count_wr_tick_b", db, 32'd100);
    bus_read(8'h00, 9'h0, da, db);
    check("count_after_tick_a", da, 32'd99);

    // Randomised traffic with a mid-run reset
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) begin
        idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end else begin
        rand_req();
        tick();
      end
    end
    idle();
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hwtimer_bank.md
# hwtimer_bank

Parametrised multi-channel timer/interrupt block on the hardware-register bus, the next generation of the single free-running timer in the hwregs block. It provides NUM_TIMERS independent down-counters, each with a prescaler, reload value, one-shot or auto-reload mode and a sticky pending flag. The pending flags are combined into per-channel and global interrupt outputs. The block sits behind the hwregs address decoder at a dedicated 256-byte window and uses the same request/response bus protocol.

## Interface
- NUM_TIMERS, 4, number of channels, legal 1..8
- WIDTH, 32, counter and reload width, legal 8..32
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- tmr_request  in  1  bus read or write request, single cycle
- tmr_write  in  1  1 = write, 0 = read
- tmr_address  in  8  byte address in window; bits [1:0] ignored
- tmr_wmask  in  4  write byte-lane enables
- tmr_wdata  in  32  write data; on reads bits [8:0] carry the tag
- tmr_rvalid  out  1  read response valid
- tmr_rtag  out  9  tag echoed from tmr_wdata[8:0] of the read
- tmr_rdata  out  32  read data
- timer_irq  out  NUM_TIMERS  per-channel pending & irq_enable
- irq  out  1  OR of timer_irq

## Operation
- Register map: channel n at 0x10*n. +0x0 COUNT (R/W), +0x4 RELOAD (R/W), +0x8 CTRL (R/W), +0xC STATUS (R, W1C). 0x80 IRQ_STATUS: read returns the pending bitmask; writing 1 to a bit clears that pending flag.
- CTRL fields: bit0 enable, bit1 auto_reload, bit2 irq_enable, bits[31:16] prescale. All other bits read 0.
- STATUS: bit0 = pending.
- Writes honour tmr_wmask per byte lane. For WIDTH<32, COUNT/RELOAD bits above WIDTH-1 are ignored on write and read 0.
- Reads of unmapped addresses, including channels ≥ NUM_TIMERS, return 0 and still produce rvalid.
- Per-channel prescaler pcnt (16 bits):
  - While enabled: if pcnt == prescale, a tick occurs and pcnt <= 0; otherwise pcnt increments.
  - While disabled: pcnt holds 0.
- On tick with COUNT != 0: COUNT decrements by 1.
- On tick with COUNT == 0 (expiry):
  - pending <= 1.
  - If auto_reload: COUNT <= RELOAD.
  - Otherwise: COUNT stays 0 and enable <= 0 (one-shot).
- Auto-reload period = (prescale+1)*(RELOAD+1) cycles. Arithmetic is unsigned; COUNT never wraps below 0.
- timer_irq[n] = pending[n] & irq_enable[n], combinational from registered state. irq = |timer_irq.

## Timing
- Reset values: every COUNT, RELOAD, CTRL, pending and pcnt = 0; tmr_rvalid = 0, tmr_rtag = 0, tmr_rdata = 0, timer_irq = 0, irq = 0.
- Reset mid-count aborts all channels immediately. No expiry is reported for the reset cycle.
- Read latency: exactly 1 cycle. tmr_rvalid is high for one cycle after the request, with tmr_rdata and tmr_rtag registered.
  - Reads return state as of the request cycle, i.e. before that cycle's update.
  - tmr_rdata = 0 whenever tmr_rvalid = 0.
- Writes take effect at the clock edge ending the request cycle. There is no write response.
- No back-pressure: a new request is accepted every cycle.
- Simultaneous events, required behaviour:
  - COUNT write in the same cycle as a tick: the written value wins and pcnt <= 0.
  - CTRL write that sets enable from 0: pcnt <= 0. The first tick occurs prescale+1 cycles after the write edge.
  - CTRL write that clears enable in an expiry cycle: the expiry is still recorded (pending <= 1); COUNT follows the expiry rule.
  - W1C of pending (STATUS or IRQ_STATUS) in an expiry cycle: the set wins, so pending stays 1.
  - W1C with the wdata bit = 0 leaves pending unchanged.
- Channels are fully independent; simultaneous expiries on several channels all set their pending flags in the same cycle.

## Test plan
- Reset, then read every address 0x00..0x84 with tag 0x1A5 → rvalid exactly 1 cycle later, rtag = 0x1A5, rdata = 0 everywhere, irq = 0.
- Ch0: RELOAD = 4, COUNT = 4, CTRL = 0x7 (prescale 0) → COUNT sequence 4,3,2,1,0,4,… and pending set every 5 cycles. irq rises in the same cycle pending reads 1.
- Ch1 one-shot: COUNT = 2, CTRL = 0x00030005 → expiry 12 cycles after the enable write. CTRL reads 0x00030004 afterwards, COUNT holds 0, pending = 1.
- W1C collision: IRQ_STATUS write 0x1 in the exact cycle ch0 expires → pending[0] stays 1. A write 0x1 one cycle later clears it and irq falls.
- Byte lanes: RELOAD write 0xAABBCCDD with wmask 0010 → RELOAD reads 0x0000CC00.
- WIDTH = 16, NUM_TIMERS = 2:
  - COUNT write 0xFFFFFFFF → reads 0x0000FFFF.
  - Read of 0x20 → 0.
  - COUNT write coinciding with a tick → the written value is loaded, with no decrement.
